// File: rtl/axis_mm_sched.sv
// rtl/axis_mm_sched.sv - matrix-multiply job scheduler between AXI-Stream inputs, core buffers and result stream
//
// Each job loads N_IBEATS input beats and N_WBEATS weight beats into the core
// buffers (the two streams are accepted independently). Once both are full,
// the block pulses core_start and waits for core_done. It then drains
// N_OBEATS result beats to m_axis, and returns to LOAD for the next job.
// tdata is not routed through this block: only handshakes and addresses are.
//
// Optional feature macro: SCHED_TLAST_CHECK_EN. When it is defined, err sets
// sticky on any accepted input beat whose tlast disagrees with its position.
// When it is not defined, err is tied low.
//
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   s_axis_i_tvalid/tlast/tready input-matrix stream handshake
//   s_axis_w_tvalid/tlast/tready weight stream handshake
//   core_i_wr_en, core_i_addr    core input-buffer write strobe / beat address
//   core_w_wr_en, core_w_addr    core weight-buffer write strobe / beat address
//   core_start, core_done        one-cycle start pulse / completion pulse
//   core_rd_addr                 result beat address (core data is combinational on it)
//   m_axis_tvalid/tlast/tready   result stream handshake
//   busy                         low only when idle in LOAD with nothing loaded
//   err                          sticky tlast framing error
module axis_mm_sched #(
    parameter int N_IBEATS = 4,
    parameter int N_WBEATS = 6,
    parameter int N_OBEATS = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        s_axis_i_tvalid,
    input  logic                        s_axis_i_tlast,
    output logic                        s_axis_i_tready,
    input  logic                        s_axis_w_tvalid,
    input  logic                        s_axis_w_tlast,
    output logic                        s_axis_w_tready,
    output logic                        core_i_wr_en,
    output logic [$clog2(N_IBEATS)-1:0] core_i_addr,
    output logic                        core_w_wr_en,
    output logic [$clog2(N_WBEATS)-1:0] core_w_addr,
    output logic                        core_start,
    input  logic                        core_done,
    output logic [$clog2(N_OBEATS)-1:0] core_rd_addr,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic                        busy,
    output logic                        err
);

    localparam int IAW = $clog2(N_IBEATS);
    localparam int WAW = $clog2(N_WBEATS);
    localparam int OAW = $clog2(N_OBEATS);
    // Load counters must be able to hold the full count, one past the last address.
    localparam int ICW = $clog2(N_IBEATS + 1);
    localparam int WCW = $clog2(N_WBEATS + 1);

    localparam logic [ICW-1:0] I_MAX  = ICW'(N_IBEATS);
    localparam logic [ICW-1:0] I_LAST = ICW'(N_IBEATS - 1);
    localparam logic [ICW-1:0] I_ONE  = ICW'(1);
    localparam logic [WCW-1:0] W_MAX  = WCW'(N_WBEATS);
    localparam logic [WCW-1:0] W_LAST = WCW'(N_WBEATS - 1);
    localparam logic [WCW-1:0] W_ONE  = WCW'(1);
    localparam logic [OAW-1:0] O_LAST = OAW'(N_OBEATS - 1);
    localparam logic [OAW-1:0] O_ONE  = OAW'(1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [ICW-1:0] i_cnt, i_cnt_nxt;
    logic [WCW-1:0] w_cnt, w_cnt_nxt;
    logic [OAW-1:0] o_cnt, o_cnt_nxt;
    logic           i_hs, w_hs;

    // tready is gated by areset so that every output is low while reset is held,
    // even though the state register already sits in LOAD.
    assign s_axis_i_tready = !areset && (state == LOAD) && (i_cnt < I_MAX);
    assign s_axis_w_tready = !areset && (state == LOAD) && (w_cnt < W_MAX);
    assign i_hs            = s_axis_i_tvalid && s_axis_i_tready;
    assign w_hs            = s_axis_w_tvalid && s_axis_w_tready;

    assign core_i_wr_en  = i_hs;
    assign core_i_addr   = i_cnt[IAW-1:0];
    assign core_w_wr_en  = w_hs;
    assign core_w_addr   = w_cnt[WAW-1:0];
    assign core_start    = (state == START);
    assign core_rd_addr  = o_cnt;
    assign m_axis_tvalid = (state == DRAIN);
    assign m_axis_tlast  = (state == DRAIN) && (o_cnt == O_LAST);
    assign busy          = !((state == LOAD) && (i_cnt == '0) && (w_cnt == '0));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= LOAD;
            i_cnt <= '0;
            w_cnt <= '0;
            o_cnt <= '0;
        end else begin
            state <= state_nxt;
            i_cnt <= i_cnt_nxt;
            w_cnt <= w_cnt_nxt;
            o_cnt <= o_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        i_cnt_nxt = i_cnt;
        w_cnt_nxt = w_cnt;
        o_cnt_nxt = o_cnt;
        case (state)
            LOAD: begin
                if (i_hs) i_cnt_nxt = i_cnt + I_ONE;
                if (w_hs) w_cnt_nxt = w_cnt + W_ONE;
                // Look at the post-edge counts so that START follows the final
                // beat directly, whichever stream finishes last (or both together).
                if ((i_cnt_nxt == I_MAX) && (w_cnt_nxt == W_MAX)) state_nxt = START;
            end
            START: state_nxt = WAIT;
            WAIT: begin
                if (core_done) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (m_axis_tready) begin
                    if (o_cnt == O_LAST) begin
                        i_cnt_nxt = '0;
                        w_cnt_nxt = '0;
                        o_cnt_nxt = '0;
                        state_nxt = LOAD;
                    end else begin
                        o_cnt_nxt = o_cnt + O_ONE;
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

`ifdef SCHED_TLAST_CHECK_EN
    logic err_q;

    // Framing is only reported; the job still advances on beat counts alone.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_q <= 1'b0;
        end else if ((i_hs && (s_axis_i_tlast != (i_cnt == I_LAST))) ||
                     (w_hs && (s_axis_w_tlast != (w_cnt == W_LAST)))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_tlast;

    assign unused_tlast = s_axis_i_tlast ^ s_axis_w_tlast;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_axis_mm_sched.sv
// tb/tb_axis_mm_sched.sv - self-checking bench for axis_mm_sched
module tb_axis_mm_sched;

    localparam int NI = 4;
    localparam int NW = 6;
    localparam int NO = 4;

    logic       aclk = 1'b0;
    logic       areset;
    logic       s_axis_i_tvalid, s_axis_i_tlast, s_axis_i_tready;
    logic       s_axis_w_tvalid, s_axis_w_tlast, s_axis_w_tready;
    logic       core_i_wr_en, core_w_wr_en;
    logic [1:0] core_i_addr;
    logic [2:0] core_w_addr;
    logic       core_start, core_done;
    logic [1:0] core_rd_addr;
    logic       m_axis_tready, m_axis_tvalid, m_axis_tlast;
    logic       busy, err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_o_q[$];
    bit err_exp  = 1'b0;

    axis_mm_sched #(.N_IBEATS(NI), .N_WBEATS(NW), .N_OBEATS(NO)) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axis_i_tvalid(s_axis_i_tvalid),
        .s_axis_i_tlast(s_axis_i_tlast),
        .s_axis_i_tready(s_axis_i_tready),
        .s_axis_w_tvalid(s_axis_w_tvalid),
        .s_axis_w_tlast(s_axis_w_tlast),
        .s_axis_w_tready(s_axis_w_tready),
        .core_i_wr_en(core_i_wr_en),
        .core_i_addr(core_i_addr),
        .core_w_wr_en(core_w_wr_en),
        .core_w_addr(core_w_addr),
        .core_start(core_start),
        .core_done(core_done),
        .core_rd_addr(core_rd_addr),
        .m_axis_tready(m_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
        .busy(busy),
        .err(err)
    );

    always #5 aclk = ~aclk;

    task automatic adv();
        @(posedge aclk);
        #1;
    endtask

    task automatic smp();
        @(negedge aclk);
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        areset = 1'b1;
        s_axis_i_tvalid = 1'b1; s_axis_w_tvalid = 1'b1;
        s_axis_i_tlast = 1'b0;  s_axis_w_tlast = 1'b0;
        m_axis_tready = 1'b1;   core_done = 1'b1;
        adv();
        smp();
        outs = {s_axis_i_tready, s_axis_w_tready, core_i_wr_en, core_w_wr_en, core_i_addr,
                core_w_addr, core_start, core_rd_addr, m_axis_tvalid, m_axis_tlast, busy, err};
        n_checks++;
        if (outs !== 16'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0000", outs);
        end
        adv();
        areset = 1'b0;
        s_axis_i_tvalid = 1'b0; s_axis_w_tvalid = 1'b0;
        core_done = 1'b0;       m_axis_tready = 1'b0;
        smp();
        n_checks++;
        if ({s_axis_i_tready, s_axis_w_tready, busy, err} !== 4'b1100) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 1100",
                     {s_axis_i_tready, s_axis_w_tready, busy, err});
        end
        adv();
    endtask

    // Loads one job; i stream starts at cycle i_start, w stream at cycle 0.
    // bad_i names an i beat that gets a spurious tlast (-1 for none).
    task automatic load_job(input int i_start, input int bad_i);
        int  i_sent, w_sent, cyc, e;
        int  exp_i_q[$], exp_w_q[$];
        bit  i_exp_hs, w_exp_hs;
        i_sent = 0; w_sent = 0; cyc = 0;
        while ((i_sent < NI || w_sent < NW) && cyc < 60) begin
            s_axis_i_tvalid = (cyc >= i_start);
            s_axis_i_tlast  = (i_sent == NI - 1) || (i_sent == bad_i);
            s_axis_w_tvalid = 1'b1;
            s_axis_w_tlast  = (w_sent == NW - 1);
            i_exp_hs = s_axis_i_tvalid && (i_sent < NI);
            w_exp_hs = (w_sent < NW);
            if (i_exp_hs) exp_i_q.push_back(i_sent);
            if (w_exp_hs) exp_w_q.push_back(w_sent);
            smp();
            n_checks++;
            if (s_axis_i_tready !== (i_sent < NI)) begin
                n_fail++; $display("FAIL i_tready cyc%0d: got %b expected %b", cyc, s_axis_i_tready, i_sent < NI);
            end
            n_checks++;
            if (s_axis_w_tready !== (w_sent < NW)) begin
                n_fail++; $display("FAIL w_tready cyc%0d: got %b expected %b", cyc, s_axis_w_tready, w_sent < NW);
            end
            n_checks++;
            if ({core_i_wr_en, core_w_wr_en} !== {i_exp_hs, w_exp_hs}) begin
                n_fail++; $display("FAIL wr_en cyc%0d: got %b%b expected %b%b", cyc,
                                   core_i_wr_en, core_w_wr_en, i_exp_hs, w_exp_hs);
            end
            if (core_i_wr_en) begin
                n_checks++;
                if (exp_i_q.size() == 0) begin
                    n_fail++; $display("FAIL i_addr cyc%0d: got %0d expected no write", cyc, core_i_addr);
                end else begin
                    e = exp_i_q.pop_front();
                    if (core_i_addr !== 2'(e)) begin
                        n_fail++; $display("FAIL i_addr cyc%0d: got %0d expected %0d", cyc, core_i_addr, e);
                    end
                end
            end
            if (core_w_wr_en) begin
                n_checks++;
                if (exp_w_q.size() == 0) begin
                    n_fail++; $display("FAIL w_addr cyc%0d: got %0d expected no write", cyc, core_w_addr);
                end else begin
                    e = exp_w_q.pop_front();
                    if (core_w_addr !== 3'(e)) begin
                        n_fail++; $display("FAIL w_addr cyc%0d: got %0d expected %0d", cyc, core_w_addr, e);
                    end
                end
            end
            n_checks++;
            if ({core_start, busy, err} !== {1'b0, (i_sent + w_sent) != 0, err_exp}) begin
                n_fail++; $display("FAIL load_status cyc%0d: got %b expected %b", cyc,
                                   {core_start, busy, err}, {1'b0, (i_sent + w_sent) != 0, err_exp});
            end
`ifdef SCHED_TLAST_CHECK_EN
            if (i_exp_hs && (s_axis_i_tlast != (i_sent == NI - 1))) err_exp = 1'b1;
`endif
            if (i_exp_hs) i_sent++;
            if (w_exp_hs) w_sent++;
            adv();
            cyc++;
        end
        n_checks++;
        if (cyc >= 60 || exp_i_q.size() != 0 || exp_w_q.size() != 0) begin
            n_fail++; $display("FAIL load_complete: got cyc=%0d left=%0d/%0d expected all beats written",
                               cyc, exp_i_q.size(), exp_w_q.size());
        end
        // valids stay high here: nothing may be accepted in START
        smp();
        n_checks++;
        if ({core_start, s_axis_i_tready, s_axis_w_tready, core_i_wr_en, core_w_wr_en, m_axis_tvalid, busy}
                !== 7'b1000001) begin
            n_fail++; $display("FAIL start_cycle: got %b expected 1000001",
                               {core_start, s_axis_i_tready, s_axis_w_tready, core_i_wr_en,
                                core_w_wr_en, m_axis_tvalid, busy});
        end
        adv();
        s_axis_i_tvalid = 1'b0; s_axis_w_tvalid = 1'b0;
        s_axis_i_tlast  = 1'b0; s_axis_w_tlast  = 1'b0;
    endtask

    // core_done arrives `delay` cycles after the START cycle.
    task automatic run_core(input int delay);
        for (int k = 1; k < delay; k++) begin
            smp();
            n_checks++;
            if ({core_start, m_axis_tvalid, s_axis_i_tready, s_axis_w_tready, busy} !== 5'b00001) begin
                n_fail++; $display("FAIL wait_state k%0d: got %b expected 00001", k,
                                   {core_start, m_axis_tvalid, s_axis_i_tready, s_axis_w_tready, busy});
            end
            adv();
        end
        core_done = 1'b1;
        for (int a = 0; a < NO; a++) exp_o_q.push_back((a << 1) | int'(a == NO - 1));
        smp();
        adv();
        core_done = 1'b0;
    endtask

    // pat[k] is m_axis_tready for drain cycle k (k < 4), then held high.
    task automatic drain(input logic [3:0] pat);
        int k, e;
        bit done;
        k = 0; done = 1'b0;
        while (!done && k < 40) begin
            m_axis_tready = (k < 4) ? pat[k] : 1'b1;
            smp();
            n_checks++;
            if (m_axis_tvalid !== (exp_o_q.size() != 0)) begin
                n_fail++; $display("FAIL drain_tvalid k%0d: got %b expected %b", k, m_axis_tvalid, exp_o_q.size() != 0);
            end
            if (exp_o_q.size() != 0) begin
                e = exp_o_q[0];
                n_checks++;
                if ({core_rd_addr, m_axis_tlast} !== 3'(e)) begin
                    n_fail++; $display("FAIL drain_beat k%0d: got addr=%0d last=%b expected addr=%0d last=%0d",
                                       k, core_rd_addr, m_axis_tlast, e >> 1, e & 1);
                end
                if (m_axis_tvalid && m_axis_tready) e = exp_o_q.pop_front();
            end
            if (exp_o_q.size() == 0) done = 1'b1;
            adv();
            k++;
        end
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL drain_timeout: got %0d beats left expected 0", exp_o_q.size());
        end
        smp();
        n_checks++;
        if ({m_axis_tvalid, busy, s_axis_i_tready, err} !== {3'b001, err_exp}) begin
            n_fail++; $display("FAIL back_to_load: got %b expected %b",
                               {m_axis_tvalid, busy, s_axis_i_tready, err}, {3'b001, err_exp});
        end
        adv();
    endtask

    task automatic test_basic();
        load_job(0, -1);
        run_core(5);
        drain(4'b1111);
    endtask

    task automatic test_backpressure();
        load_job(0, -1);
        run_core(3);
        drain(4'b1001);
    endtask

    task automatic test_tlast();
        load_job(0, 2);
        run_core(2);
        drain(4'b1111);
        smp();
        n_checks++;
        if (err !== err_exp) begin
            n_fail++; $display("FAIL err_held: got %b expected %b", err, err_exp);
        end
        adv();
        areset = 1'b1;
        smp();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL err_reset: got %b expected 0", err);
        end
        adv();
        areset  = 1'b0;
        err_exp = 1'b0;
    endtask

    task automatic test_midjob_reset();
        logic [15:0] outs;
        load_job(0, -1);
        repeat (3) begin
            smp();
            adv();
        end
        areset = 1'b1;
        s_axis_i_tvalid = 1'b1; s_axis_w_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        smp();
        outs = {s_axis_i_tready, s_axis_w_tready, core_i_wr_en, core_w_wr_en, core_i_addr,
                core_w_addr, core_start, core_rd_addr, m_axis_tvalid, m_axis_tlast, busy, err};
        n_checks++;
        if (outs !== 16'h0) begin
            n_fail++; $display("FAIL midjob_reset_outputs: got %h expected 0000", outs);
        end
        adv();
        areset = 1'b0;
        s_axis_i_tvalid = 1'b0; s_axis_w_tvalid = 1'b0;
        core_done = 1'b1;
        smp();
        adv();
        core_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            smp();
            n_checks++;
            if ({m_axis_tvalid, core_start, busy} !== 3'b000) begin
                n_fail++; $display("FAIL late_done k%0d: got %b expected 000", k, {m_axis_tvalid, core_start, busy});
            end
            adv();
        end
    endtask

    task automatic test_same_cycle();
        load_job(NW - NI, -1);
        run_core(4);
        drain(4'b1111);
    endtask

    initial begin
        areset = 1'b1;
        s_axis_i_tvalid = 1'b0; s_axis_i_tlast = 1'b0;
        s_axis_w_tvalid = 1'b0; s_axis_w_tlast = 1'b0;
        core_done = 1'b0;       m_axis_tready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_tlast();
        test_midjob_reset();
        test_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
